// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Round-robin arbiter that shares one combinational sliced ALU
//               between two requesters. It latches the winner's operands,
//               drives the ALU for one cycle, registers RESULT/CMP and returns
//               a tagged response over a valid/ready handshake.
//               Optional build macro: ALU_ARB_STATS_EN adds saturating
//               grant/error counters (gnt0_cnt, gnt1_cnt, err_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int S   = 4,   // slice width, must match the ALU instance
    parameter int N_A = 2    // number of slices
) (
    input  logic               clk,
    input  logic               rst,

    // requester 0
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [N_A*S-1:0]   req0_a,
    input  logic [N_A*S-1:0]   req0_b,
    input  logic [2:0]         req0_op,

    // requester 1
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [N_A*S-1:0]   req1_a,
    input  logic [N_A*S-1:0]   req1_b,
    input  logic [2:0]         req1_op,

    // external ALU connection
    output logic [N_A*S-1:0]   alu_a,
    output logic [N_A*S-1:0]   alu_b,
    output logic [2:0]         alu_op,
    input  logic [N_A*S-1:0]   alu_result,
    input  logic [1:0]         alu_cmp,

    // response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [N_A*S-1:0]   rsp_result,
    output logic [1:0]         rsp_cmp,
    output logic               rsp_err,

    output logic               busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        gnt0_cnt,
    output logic [15:0]        gnt1_cnt,
    output logic [7:0]         err_cnt
`endif
);

    localparam int W = N_A * S;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_last_grant;

    // ALU-facing operand registers; only legal ops ever load them so the ALU
    // inputs never toggle for an op that bypasses the datapath.
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [2:0]      r_op;

    logic            r_id;
    logic [W-1:0]    r_rsp_result;
    logic [1:0]      r_rsp_cmp;
    logic            r_rsp_err;

    logic            w_grant_valid;
    logic            w_grant_id;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [2:0]      w_sel_op;
    logic            w_sel_unsup;

    // Round-robin pick: a lone requester wins; on a tie the one that did not
    // win last time goes. Only evaluated while idle so arbitration is frozen
    // for the whole EXEC/RESP window.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (r_state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = ~r_last_grant;
            end else if (req0_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b0;
            end else if (req1_valid) begin
                w_grant_valid = 1'b1;
                w_grant_id    = 1'b1;
            end
        end
    end

    // Steer the winning requester's operation toward the latch registers.
    always_comb begin
        w_sel_a     = w_grant_id ? req1_a  : req0_a;
        w_sel_b     = w_grant_id ? req1_b  : req0_b;
        w_sel_op    = w_grant_id ? req1_op : req0_op;
        w_sel_unsup = w_sel_op[2];
    end

    // Next-state and handshake outputs; ready is a pure function of the
    // current grant so it can never be high for both requesters.
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy       = 1'b0;
                req0_ready = w_grant_valid & ~w_grant_id;
                req1_ready = w_grant_valid &  w_grant_id;
                if (w_grant_valid) begin
                    // unsupported opcodes skip the ALU cycle entirely
                    w_state_nxt = w_sel_unsup ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping: owner tag and round-robin history. Resetting the
    // history to 1 lets requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
        end else if (w_grant_valid) begin
            r_last_grant <= w_grant_id;
            r_id         <= w_grant_id;
        end
    end

    // Operand latch feeding the ALU; held through EXEC and while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_op <= '0;
        end else if (w_grant_valid && !w_sel_unsup) begin
            r_a  <= w_sel_a;
            r_b  <= w_sel_b;
            r_op <= w_sel_op;
        end
    end

    // Response registers: loaded from the ALU at the end of EXEC, or with an
    // error response directly on an unsupported grant. Nothing can load them
    // while in RESP, which keeps the response stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_result <= '0;
            r_rsp_cmp    <= '0;
            r_rsp_err    <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_rsp_result <= alu_result;
            r_rsp_cmp    <= alu_cmp;
            r_rsp_err    <= 1'b0;
        end else if (w_grant_valid && w_sel_unsup) begin
            r_rsp_result <= '0;
            r_rsp_cmp    <= '0;
            r_rsp_err    <= 1'b1;
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;
    assign rsp_id     = r_id;
    assign rsp_result = r_rsp_result;
    assign rsp_cmp    = r_rsp_cmp;
    assign rsp_err    = r_rsp_err;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_gnt0_cnt;
    logic [15:0] r_gnt1_cnt;
    logic [7:0]  r_err_cnt;

    // Saturating per-requester grant counters and unsupported-op counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
            r_err_cnt  <= '0;
        end else if (w_grant_valid) begin
            if (!w_grant_id && (r_gnt0_cnt != 16'hFFFF)) begin
                r_gnt0_cnt <= r_gnt0_cnt + 16'd1;
            end
            if (w_grant_id && (r_gnt1_cnt != 16'hFFFF)) begin
                r_gnt1_cnt <= r_gnt1_cnt + 16'd1;
            end
            if (w_sel_unsup && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign gnt0_cnt = r_gnt0_cnt;
    assign gnt1_cnt = r_gnt1_cnt;
    assign err_cnt  = r_err_cnt;
`endif

endmodule
`default_nettype wire
